// File: rtl/pcie_msgq_pkg.sv
// ---------------------------------------------------------------------------
// pcie_msgq_pkg
// Shared definitions for the assembled-message queue controller:
//   - allocation FSM state encoding
//   - pointer-width derivation (offset bits plus one wrap bit)
//   - bit offsets of the fields packed into o_err_status
//   - base bit of the optional overflow interrupt bits (PCIE_MSGQ_OVF_INTR_EN)
// No ports; imported by pcie_msg_queue_ctrl and pcie_msgq_ring_ptr.
// ---------------------------------------------------------------------------
package pcie_msgq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } msgq_state_e;

    // Overflow (rejected allocation) status bits start here in Q_INTR_STATUS
    localparam int MSGQ_OVF_BIT_BASE = 16;

    // o_err_status field layout
    localparam int ERR_REJ_CNT_LSB = 0;
    localparam int ERR_BAD_CNT_LSB = 8;
    localparam int ERR_REJ_TAG_LSB = 16;
    localparam int ERR_CNT_W       = 8;
    localparam int ERR_TAG_W       = 4;

    // Ring pointers carry one extra MSB so that full and empty differ
    function automatic int msgq_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pcie_msgq_ring_ptr.sv
// ---------------------------------------------------------------------------
// pcie_msgq_ring_ptr
// Write/read pointer pair for a single message queue ring.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   adv_en       advance wptr by adv_len this cycle (granted allocation)
//   adv_len      beats to advance (never exceeds free space when granted)
//   rptr_wr      software read-pointer write strobe for this queue
//   rptr_val     proposed read pointer including wrap bit
//   wptr         current write pointer including wrap bit
//   free         free beats in the ring, Q_DEPTH - occupancy
//   rptr_bad     rptr_wr seen with a value outside the occupied window
// ---------------------------------------------------------------------------
module pcie_msgq_ring_ptr
    import pcie_msgq_pkg::*;
#(
    parameter int Q_DEPTH = 64,
    parameter int PW      = msgq_ptr_width(Q_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv_en,
    input  logic [PW-1:0] adv_len,
    input  logic          rptr_wr,
    input  logic [PW-1:0] rptr_val,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] free,
    output logic          rptr_bad
);

    logic [PW-1:0] rptr;
    logic [PW-1:0] occ;
    logic [PW-1:0] rptr_delta;
    logic          rptr_ok;

    // Modulo-2**PW arithmetic makes the wrap bit fall out naturally.
    // A new rptr may only move forward, and never past wptr.
    always_comb begin
        occ        = wptr - rptr;
        free       = PW'(Q_DEPTH) - occ;
        rptr_delta = rptr_val - rptr;
        rptr_ok    = (rptr_delta <= occ);
        rptr_bad   = rptr_wr && !rptr_ok;
    end

    // Grant advance and software drain are independent and may both land
    // in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (adv_en) begin
                wptr <= wptr + adv_len;
            end
            if (rptr_wr && rptr_ok) begin
                rptr <= rptr_val;
            end
        end
    end

endmodule

// File: rtl/pcie_msg_queue_ctrl.sv
// ---------------------------------------------------------------------------
// pcie_msg_queue_ctrl
// Ring-buffer space allocator for the assembled-message SRAM region, one ring
// per queue tag, plus completion interrupts and software read-pointer writes.
// Optional feature macro: PCIE_MSGQ_OVF_INTR_EN -- a rejected allocation with
// a valid tag also sets intr_status[16+tag] (requires NUM_Q <= 16).
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   i_alloc_req/tag/len                allocation request (held until ack)
//   o_alloc_ready                      FSM idle, request will be sampled
//   o_alloc_ack/ok/addr                one-cycle response, grant flag, address
//   i_done, i_done_tag                 message completion pulse
//   i_rptr_wr/q/val                    software read-pointer write
//   i_wptr_sel, o_q_data_wptr          Q_DATA_WPTR readback (1-cycle latency)
//   o_q_init_addr                      Q_INIT_ADDR per queue, q*32 slice
//   i_intr_clear, o_intr_status        Q_INTR_CLEAR (W1C) / Q_INTR_STATUS
//   o_err_status                       reject count, bad-rptr count, last tag
//   o_msg_interrupt                    registered OR of o_intr_status
// ---------------------------------------------------------------------------
module pcie_msg_queue_ctrl
    import pcie_msgq_pkg::*;
#(
    parameter int NUM_Q      = 15,
    parameter int Q_DEPTH    = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 12,
    localparam int PW        = msgq_ptr_width(Q_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_alloc_req,
    input  logic [3:0]            i_alloc_tag,
    input  logic [LEN_WIDTH-1:0]  i_alloc_len,
    output logic                  o_alloc_ready,
    output logic                  o_alloc_ack,
    output logic                  o_alloc_ok,
    output logic [ADDR_WIDTH-1:0] o_alloc_addr,
    input  logic                  i_done,
    input  logic [3:0]            i_done_tag,
    input  logic                  i_rptr_wr,
    input  logic [3:0]            i_rptr_q,
    input  logic [PW-1:0]         i_rptr_val,
    input  logic [3:0]            i_wptr_sel,
    output logic [31:0]           o_q_data_wptr,
    output logic [NUM_Q*32-1:0]   o_q_init_addr,
    input  logic [31:0]           i_intr_clear,
    output logic [31:0]           o_intr_status,
    output logic [31:0]           o_err_status,
    output logic                  o_msg_interrupt
);

    localparam logic [4:0] NUM_Q_LIM = 5'(NUM_Q);

    msgq_state_e           state;
    logic [3:0]            tag_q;
    logic [LEN_WIDTH-1:0]  len_q;

    logic [PW-1:0]         wptr_arr [NUM_Q];
    logic [PW-1:0]         free_arr [NUM_Q];
    logic [NUM_Q-1:0]      bad_arr;

    logic [PW-1:0]         sel_wptr;
    logic [PW-1:0]         sel_free;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [PW-1:0]         rd_wptr;
    logic                  tag_valid;
    logic                  reject;
    logic                  grant;
    logic                  rptr_bad_any;
    logic [31:0]           set_vec;

    logic [ERR_CNT_W-1:0]  rej_cnt;
    logic [ERR_CNT_W-1:0]  bad_cnt;
    logic [ERR_TAG_W-1:0]  rej_tag;

    assign o_alloc_ready = (state == ST_IDLE);

    // One ring per queue; Q_INIT_ADDR is a constant base per queue
    for (genvar q = 0; q < NUM_Q; q++) begin : g_ring
        pcie_msgq_ring_ptr #(
            .Q_DEPTH (Q_DEPTH),
            .PW      (PW)
        ) u_ring (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv_en   (grant && (tag_q == 4'(q))),
            .adv_len  (len_q[PW-1:0]),
            .rptr_wr  (i_rptr_wr && (i_rptr_q == 4'(q))),
            .rptr_val (i_rptr_val),
            .wptr     (wptr_arr[q]),
            .free     (free_arr[q]),
            .rptr_bad (bad_arr[q])
        );
        assign o_q_init_addr[q*32 +: 32] = 32'(q * Q_DEPTH);
    end

    // Select the latched tag's ring state; an out-of-range tag selects
    // nothing and is rejected anyway
    always_comb begin
        sel_wptr = '0;
        sel_free = '0;
        sel_base = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (tag_q == 4'(q)) begin
                sel_wptr = wptr_arr[q];
                sel_free = free_arr[q];
                sel_base = ADDR_WIDTH'(q * Q_DEPTH);
            end
        end
    end

    // Free space is sampled from the pre-update rptr, so a concurrent
    // software drain can only make this decision more conservative
    always_comb begin
        tag_valid = ({1'b0, tag_q} < NUM_Q_LIM);
        reject    = !tag_valid || (len_q == '0) ||
                    (len_q > LEN_WIDTH'(sel_free));
        grant     = (state == ST_CHECK) && !reject;
    end

    // Allocation FSM. The ring advances on the CHECK->RESP edge, the same
    // edge that registers the ack, so wptr already reflects the grant while
    // the ack is visible. A request dropped early is still completed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tag_q        <= '0;
            len_q        <= '0;
            o_alloc_ack  <= 1'b0;
            o_alloc_ok   <= 1'b0;
            o_alloc_addr <= '0;
        end else begin
            o_alloc_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_alloc_req) begin
                        tag_q <= i_alloc_tag;
                        len_q <= i_alloc_len;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state       <= ST_RESP;
                    o_alloc_ack <= 1'b1;
                    o_alloc_ok  <= !reject;
                    if (reject) begin
                        o_alloc_addr <= '0;
                    end else begin
                        o_alloc_addr <= sel_base + ADDR_WIDTH'(sel_wptr[PW-2:0]);
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    o_alloc_ok   <= 1'b0;
                    o_alloc_addr <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Writes to a nonexistent queue count as bad just like out-of-window ones
    always_comb begin
        rptr_bad_any = (|bad_arr) ||
                       (i_rptr_wr && !({1'b0, i_rptr_q} < NUM_Q_LIM));
    end

    // Saturating error counters and the tag of the most recent reject
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rej_cnt <= '0;
            bad_cnt <= '0;
            rej_tag <= '0;
        end else begin
            if ((state == ST_CHECK) && reject) begin
                rej_tag <= tag_q;
                if (rej_cnt != '1) begin
                    rej_cnt <= rej_cnt + 1'b1;
                end
            end
            if (rptr_bad_any && (bad_cnt != '1)) begin
                bad_cnt <= bad_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        o_err_status = '0;
        o_err_status[ERR_REJ_CNT_LSB +: ERR_CNT_W] = rej_cnt;
        o_err_status[ERR_BAD_CNT_LSB +: ERR_CNT_W] = bad_cnt;
        o_err_status[ERR_REJ_TAG_LSB +: ERR_TAG_W] = rej_tag;
    end

    // Status set sources. Only in-range bits are ever set, so unused
    // status bits stay 0 without an explicit mask.
    always_comb begin
        set_vec = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (i_done && (i_done_tag == 4'(q))) begin
                set_vec[q] = 1'b1;
            end
`ifdef PCIE_MSGQ_OVF_INTR_EN
            if ((state == ST_CHECK) && reject && (tag_q == 4'(q))) begin
                set_vec[MSGQ_OVF_BIT_BASE + q] = 1'b1;
            end
`endif
        end
    end

    // W1C status with set taking priority; the interrupt line lags by one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_intr_status   <= '0;
            o_msg_interrupt <= 1'b0;
        end else begin
            o_intr_status   <= (o_intr_status & ~i_intr_clear) | set_vec;
            o_msg_interrupt <= |o_intr_status;
        end
    end

    // Q_DATA_WPTR readback mux; unknown queues read 0
    always_comb begin
        rd_wptr = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (i_wptr_sel == 4'(q)) begin
                rd_wptr = wptr_arr[q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q_data_wptr <= '0;
        end else begin
            o_q_data_wptr <= 32'(rd_wptr);
        end
    end

endmodule

// File: tb/tb_pcie_msg_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pcie_msg_queue_ctrl
// Directed scenarios followed by randomized traffic for pcie_msg_queue_ctrl.
// Allocation responses are predicted by a queue-level model and checked by
// an independent monitor; register views are compared directly.
// Honors PCIE_MSGQ_OVF_INTR_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pcie_msg_queue_ctrl;

    localparam int NUM_Q      = 15;
    localparam int Q_DEPTH    = 64;
    localparam int ADDR_WIDTH = 10;
    localparam int LEN_WIDTH  = 12;
    localparam int PW         = 7;
    localparam int PMOD       = 128;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  i_alloc_req = 1'b0;
    logic [3:0]            i_alloc_tag = '0;
    logic [LEN_WIDTH-1:0]  i_alloc_len = '0;
    logic                  o_alloc_ready;
    logic                  o_alloc_ack;
    logic                  o_alloc_ok;
    logic [ADDR_WIDTH-1:0] o_alloc_addr;
    logic                  i_done = 1'b0;
    logic [3:0]            i_done_tag = '0;
    logic                  i_rptr_wr = 1'b0;
    logic [3:0]            i_rptr_q = '0;
    logic [PW-1:0]         i_rptr_val = '0;
    logic [3:0]            i_wptr_sel = '0;
    logic [31:0]           o_q_data_wptr;
    logic [NUM_Q*32-1:0]   o_q_init_addr;
    logic [31:0]           i_intr_clear = '0;
    logic [31:0]           o_intr_status;
    logic [31:0]           o_err_status;
    logic                  o_msg_interrupt;

    pcie_msg_queue_ctrl #(
        .NUM_Q      (NUM_Q),
        .Q_DEPTH    (Q_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_alloc_req     (i_alloc_req),
        .i_alloc_tag     (i_alloc_tag),
        .i_alloc_len     (i_alloc_len),
        .o_alloc_ready   (o_alloc_ready),
        .o_alloc_ack     (o_alloc_ack),
        .o_alloc_ok      (o_alloc_ok),
        .o_alloc_addr    (o_alloc_addr),
        .i_done          (i_done),
        .i_done_tag      (i_done_tag),
        .i_rptr_wr       (i_rptr_wr),
        .i_rptr_q        (i_rptr_q),
        .i_rptr_val      (i_rptr_val),
        .i_wptr_sel      (i_wptr_sel),
        .o_q_data_wptr   (o_q_data_wptr),
        .o_q_init_addr   (o_q_init_addr),
        .i_intr_clear    (i_intr_clear),
        .o_intr_status   (o_intr_status),
        .o_err_status    (o_err_status),
        .o_msg_interrupt (o_msg_interrupt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected allocation responses: {ok, addr}
    logic [ADDR_WIDTH:0] exp_q[$];

    // Queue-level reference state
    int          wm [NUM_Q];
    int          rm [NUM_Q];
    int          rej_m;
    int          bad_m;
    int          tag_m;
    logic [31:0] status_m;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding prediction
    always @(negedge clk) begin
        logic [ADDR_WIDTH:0] e;
        if (o_alloc_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_ack: got ack with ok=%0d addr=%0d, none expected",
                         o_alloc_ok, o_alloc_addr);
            end else begin
                e = exp_q.pop_front();
                checkOutput("alloc_ok", 32'(o_alloc_ok), 32'(e[ADDR_WIDTH]));
                checkOutput("alloc_addr", 32'(o_alloc_addr), 32'(e[ADDR_WIDTH-1:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int occOf(input int q);
        return (wm[q] - rm[q] + PMOD) % PMOD;
    endfunction

    task automatic modelReset();
        for (int q = 0; q < NUM_Q; q++) begin
            wm[q] = 0;
            rm[q] = 0;
        end
        rej_m    = 0;
        bad_m    = 0;
        tag_m    = 0;
        status_m = '0;
    endtask

    task automatic resetDut();
        rst_n       = 1'b0;
        i_alloc_req = 1'b0;
        i_done      = 1'b0;
        i_rptr_wr   = 1'b0;
        i_intr_clear = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic doAlloc(input int tag, input int len);
        int waitCnt;
        waitCnt = 0;
        while (!o_alloc_ready && waitCnt < 20) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("alloc_ready", 32'(o_alloc_ready), 32'd1);
        if (tag >= NUM_Q || len == 0 || len > Q_DEPTH - occOf(tag)) begin
            if (rej_m < 255) rej_m++;
            tag_m = tag;
`ifdef PCIE_MSGQ_OVF_INTR_EN
            if (tag < NUM_Q) status_m[16 + tag] = 1'b1;
`endif
            exp_q.push_back({1'b0, ADDR_WIDTH'(0)});
        end else begin
            exp_q.push_back({1'b1, ADDR_WIDTH'(tag * Q_DEPTH + (wm[tag] % Q_DEPTH))});
            wm[tag] = (wm[tag] + len) % PMOD;
        end
        i_alloc_req = 1'b1;
        i_alloc_tag = 4'(tag);
        i_alloc_len = LEN_WIDTH'(len);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ack_latency", 32'(o_alloc_ack), 32'd1);
        i_alloc_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic doRptrWrite(input int q, input int val);
        if (q < NUM_Q && ((val - rm[q] + PMOD) % PMOD) <= occOf(q)) begin
            rm[q] = val;
        end else if (bad_m < 255) begin
            bad_m++;
        end
        i_rptr_wr  = 1'b1;
        i_rptr_q   = 4'(q);
        i_rptr_val = PW'(val);
        @(posedge clk);
        #1;
        i_rptr_wr = 1'b0;
    endtask

    task automatic applyStimulus(input logic done, input int tag, input logic [31:0] clr);
        logic [31:0] prev;
        prev = status_m;
        status_m = status_m & ~clr;
        if (done && tag < NUM_Q) status_m[tag] = 1'b1;
        i_done       = done;
        i_done_tag   = 4'(tag);
        i_intr_clear = clr;
        @(posedge clk);
        #1;
        i_done       = 1'b0;
        i_intr_clear = '0;
        checkOutput("intr_status", o_intr_status, status_m);
        checkOutput("msg_int_lag", 32'(o_msg_interrupt), 32'(|prev));
        @(posedge clk);
        #1;
        checkOutput("msg_int", 32'(o_msg_interrupt), 32'(|status_m));
    endtask

    task automatic checkWptr(input int q);
        i_wptr_sel = 4'(q);
        @(posedge clk);
        #1;
        checkOutput("q_data_wptr", o_q_data_wptr, (q < NUM_Q) ? 32'(wm[q]) : 32'd0);
    endtask

    task automatic checkErr();
        checkOutput("err_status", o_err_status,
                    (32'(tag_m) << 16) | (32'(bad_m) << 8) | 32'(rej_m));
    endtask

    initial begin
        int op;
        int q;
        int val;

        resetDut();

        // Reset state
        checkOutput("rst_ack", 32'(o_alloc_ack), 32'd0);
        checkOutput("rst_ok", 32'(o_alloc_ok), 32'd0);
        checkOutput("rst_addr", 32'(o_alloc_addr), 32'd0);
        checkOutput("rst_status", o_intr_status, 32'd0);
        checkOutput("rst_err", o_err_status, 32'd0);
        checkOutput("rst_int", 32'(o_msg_interrupt), 32'd0);
        checkOutput("rst_ready", 32'(o_alloc_ready), 32'd1);
        for (int i = 0; i < NUM_Q; i++) begin
            checkOutput($sformatf("init_addr%0d", i), o_q_init_addr[i*32 +: 32], 32'(i * Q_DEPTH));
        end

        // Basic grant, readback and completion interrupt
        doAlloc(3, 10);
        checkWptr(3);
        applyStimulus(1'b1, 3, 32'd0);

        // Full-queue reject
        doAlloc(0, 60);
        doAlloc(0, 5);
        checkErr();

        // Wrap across the region end
        doAlloc(1, 60);
        doRptrWrite(1, 60);
        doAlloc(1, 10);
        checkWptr(1);

        // Invalid tag, zero length, out-of-window rptr
        doAlloc(15, 4);
        doAlloc(2, 0);
        doRptrWrite(2, 5);
        checkErr();
        checkWptr(2);

        // Set beats clear on the same bit, then clear everything
        applyStimulus(1'b1, 4, 32'h10);
        applyStimulus(1'b0, 0, 32'h10);
        applyStimulus(1'b0, 0, 32'hFFFF_FFFF);

        // Reset while the FSM sits in CHECK
        i_alloc_req = 1'b1;
        i_alloc_tag = 4'd0;
        i_alloc_len = LEN_WIDTH'(5);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        i_alloc_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        checkOutput("midrst_status", o_intr_status, 32'd0);
        checkErr();
        checkWptr(1);
        checkWptr(0);
        doAlloc(0, 5);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 4);
            case (op)
                0, 1: doAlloc($urandom_range(0, 15), $urandom_range(0, 70));
                2: begin
                    q = $urandom_range(0, 15);
                    if (q < NUM_Q && $urandom_range(0, 3) != 0) begin
                        val = (rm[q] + $urandom_range(0, occOf(q))) % PMOD;
                    end else begin
                        val = $urandom_range(0, PMOD - 1);
                    end
                    doRptrWrite(q, val);
                end
                3: applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom());
                default: begin
                    checkWptr($urandom_range(0, 15));
                    checkErr();
                end
            endcase
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        checkOutput("final_status", o_intr_status, status_m);
        checkErr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
